wb_chkpt_port: RTL and testbench

//  Wishbone responder in the user area. The management core writes 16-bit

---
 rtl/wb_chkpt_if.sv | 14 +
 rtl/wb_chkpt_port.sv | 192 +++++++++++++++++++
 tb/tb_wb_chkpt_port.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_chkpt_if.sv
// Wishbone slave-side bus bundle for the checkpoint port.
interface wb_chkpt_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_chkpt_port.sv
// Wishbone responder that queues 16-bit checkpoint codes and shows each on the pads for HOLD cycles.
// Optional: define WB_CHKPT_TSTAMP_EN to capture a free-running cycle count on every code load.
module wb_chkpt_port #(
  parameter int CW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_RST   = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_chkpt_if.slave     wb,
  output logic [CW-1:0] chk_code_o,
  output logic [CW-1:0] chk_oeb_o,
  output logic          chk_busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LVL_ZERO = {(AW+1){1'b0}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHOW = 1'b1} state_e;

  state_e        state_r, state_s;
  logic          ack_r;
  logic [31:0]   dat_r;
  logic [CW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   level_r;
  logic          ovf_r, oe_en_r;
  logic [CW-1:0] oeb_r, code_r, head_s;
  logic [15:0]   hold_r, hold_eff_s, cnt_r, cnt_s, ts_field_s;
  logic [31:0]   rd_data_s;
  logic          req_s, commit_s, code_wr_s, ctrl_wr_s, stat_wr_s, hold_wr_s, flush_s;
  logic          empty_s, full_s, avail_s, load_s, pop_s, fifo_push_s, ovf_set_s;
  logic          unused_s;

  assign req_s     = wb.cyc & wb.stb & ~ack_r;
  assign commit_s  = ack_r & wb.cyc & wb.stb & wb.we;
  assign code_wr_s = commit_s & (wb.adr[3:2] == 2'd0);
  assign ctrl_wr_s = commit_s & (wb.adr[3:2] == 2'd1);
  assign stat_wr_s = commit_s & (wb.adr[3:2] == 2'd2);
  assign hold_wr_s = commit_s & (wb.adr[3:2] == 2'd3);
  assign flush_s   = ctrl_wr_s & wb.sel[0] & wb.dat_w[1];

  assign empty_s    = (level_r == LVL_ZERO);
  assign full_s     = (level_r == LVL_FULL);
  // An empty queue forwards the code being written so it reaches the pads one cycle after ack.
  assign avail_s    = ~empty_s | code_wr_s;
  assign head_s     = empty_s ? wb.dat_w[CW-1:0] : mem_r[rd_ptr_r];
  assign hold_eff_s = (hold_r == 16'd0) ? 16'd1 : hold_r;

  assign pop_s       = load_s & ~empty_s;
  assign fifo_push_s = code_wr_s & ~(load_s & empty_s) & (~full_s | pop_s);
  assign ovf_set_s   = code_wr_s & full_s & ~pop_s;

  // Display FSM next-state, hold counter and load decision.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush_s) begin
          state_s = ST_IDLE;
        end else if (avail_s) begin
          load_s  = 1'b1;
          state_s = ST_SHOW;
          cnt_s   = hold_eff_s - 16'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (flush_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r != 16'd0) begin
          cnt_s = cnt_r - 16'd1;
        end else if (avail_s) begin
          load_s = 1'b1;
          cnt_s  = hold_eff_s - 16'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Register read mux; unmapped bits stay zero.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (wb.adr[3:2])
      2'd0:    rd_data_s = 32'(code_r);
      2'd1:    rd_data_s = {31'h0000_0000, oe_en_r};
      2'd2:    rd_data_s = {ts_field_s, 10'h000, ovf_r, full_s, empty_s, 3'(level_r)};
      2'd3:    rd_data_s = {16'h0000, hold_r};
      default: rd_data_s = 32'h0000_0000;
    endcase
  end

  // Bus handshake: single-cycle ack, read data captured alongside it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= req_s;
      if (req_s & ~wb.we) dat_r <= rd_data_s;
      else                dat_r <= dat_r;
    end
  end

  // Control registers and sticky overflow flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      oe_en_r <= 1'b0;
      oeb_r   <= {CW{1'b1}};
      hold_r  <= 16'(HOLD_RST);
      ovf_r   <= 1'b0;
    end else begin
      if (ctrl_wr_s & wb.sel[0]) begin
        oe_en_r <= wb.dat_w[0];
        oeb_r   <= {CW{~wb.dat_w[0]}};
      end
      if (hold_wr_s & wb.sel[0]) hold_r[7:0]  <= wb.dat_w[7:0];
      if (hold_wr_s & wb.sel[1]) hold_r[15:8] <= wb.dat_w[15:8];
      if (ovf_set_s)                       ovf_r <= 1'b1;
      else if (stat_wr_s & wb.dat_w[5])    ovf_r <= 1'b0;
    end
  end

  // Code queue storage and pointers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {CW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= LVL_ZERO;
    end else if (flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= LVL_ZERO;
    end else begin
      if (fifo_push_s) begin
        mem_r[wr_ptr_r] <= wb.dat_w[CW-1:0];
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({fifo_push_s, pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Display FSM state, hold counter and displayed code.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
      code_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (load_s) code_r <= head_s;
    end
  end

`ifdef WB_CHKPT_TSTAMP_EN
  logic [15:0] ts_cnt_r, ts_cap_r;

  // Free-running cycle counter, sampled whenever a code is loaded.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ts_cnt_r <= 16'd0;
      ts_cap_r <= 16'd0;
    end else begin
      ts_cnt_r <= ts_cnt_r + 16'd1;
      if (load_s) ts_cap_r <= ts_cnt_r;
    end
  end
  assign ts_field_s = ts_cap_r;
`else
  assign ts_field_s = 16'h0000;
`endif

  assign wb.ack     = ack_r;
  assign wb.dat_r   = dat_r;
  assign chk_code_o = code_r;
  assign chk_oeb_o  = oeb_r;
  assign chk_busy_o = (state_r == ST_SHOW) | ~empty_s;
  assign unused_s   = ^{wb.sel[3:2], wb.adr[1:0], wb.dat_w[31:16]};
endmodule

// File: tb/tb_wb_chkpt_port.sv
// Scoreboard bench for wb_chkpt_port: bus reads and pad codes are checked by monitors against queued expectations.
module tb_wb_chkpt_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] chk_code, chk_oeb;
  logic        chk_busy;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef WB_CHKPT_TSTAMP_EN
  localparam logic [31:0] ST_MASK = 32'h0000_FFFF;
`else
  localparam logic [31:0] ST_MASK = 32'hFFFF_FFFF;
`endif

  typedef struct { string name; logic [31:0] exp; logic [31:0] mask; } rd_exp_t;
  typedef struct { logic [15:0] code; int hold; } code_exp_t;
  rd_exp_t   rd_q[$];
  code_exp_t code_q[$];
  rd_exp_t   re;
  code_exp_t ce;
  logic [31:0] last_rd = 32'h0;
  logic [15:0] last_code = 16'h0;
  logic        prev_ack = 1'b0;
  int          run_len = 0;
  int          prev_hold = 0;
  logic [15:0] ts1 = 16'h0;

  wb_chkpt_if wb();

  wb_chkpt_port dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb),
    .chk_code_o (chk_code),
    .chk_oeb_o  (chk_oeb),
    .chk_busy_o (chk_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int budget = 0;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = adr; wb.dat_w = dat; wb.sel = sel;
    do begin
      @(negedge clk);
      budget++;
    end while (!wb.ack && budget < 20);
    check("ack_seen", 32'(wb.ack), 32'd1);
    @(posedge clk); #1;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_xfer(1'b1, adr, dat, sel);
  endtask

  task automatic rd(input logic [3:0] adr, input string name, input logic [31:0] exp,
                    input logic [31:0] mask = 32'hFFFF_FFFF);
    rd_q.push_back('{name, exp, mask});
    wb_xfer(1'b0, adr, 32'h0, 4'hF);
  endtask

  task automatic exp_code(input logic [15:0] code, input int hold);
    code_q.push_back('{code, hold});
  endtask

  // Bus monitor: ack must be a lone pulse; read data is compared against the read queue.
  always @(negedge clk) begin
    if (!rst && wb.ack) begin
      check("ack_pulse", 32'(prev_ack), 32'd0);
      if (!wb.we) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", wb.dat_r, 32'hDEAD_BEEF);
        end else begin
          re = rd_q.pop_front();
          check(re.name, wb.dat_r & re.mask, re.exp & re.mask);
          last_rd = wb.dat_r;
        end
      end
    end
    prev_ack = wb.ack;
  end

  // Pad monitor: every code change must follow the expected order and hold length.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_code !== last_code) begin
        if (prev_hold != 0) check("hold_len", 32'(run_len), 32'(prev_hold));
        if (code_q.size() == 0) begin
          check("code_unexpected", 32'(chk_code), 32'(last_code));
          prev_hold = 0;
        end else begin
          ce = code_q.pop_front();
          check("code_seq", 32'(chk_code), 32'(ce.code));
          prev_hold = ce.hold;
        end
        last_code = chk_code;
        run_len   = 1;
      end else begin
        run_len++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = 4'h0; wb.adr = 4'h0; wb.dat_w = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_code", 32'(chk_code), 32'h0);
    check("rst_oeb",  32'(chk_oeb),  32'h0000_FFFF);
    check("rst_busy", 32'(chk_busy), 32'h0);
    rd(4'h0, "rd_code_rst", 32'h0);
    rd(4'h4, "rd_ctrl_rst", 32'h0);
    rd(4'h8, "rd_stat_rst", 32'h0000_0008, ST_MASK);
    rd(4'hC, "rd_hold_rst", 32'd16);
    wr(4'hC, 32'h0000_AB00, 4'b0010);
    rd(4'hC, "rd_hold_bytesel", 32'h0000_AB10);

    // Single code, HOLD=4, latency and hold window
    wr(4'h4, 32'h1, 4'b0001);
    check("oeb_enabled", 32'(chk_oeb), 32'h0);
    wr(4'hC, 32'hFFFF_0004, 4'b0011);
    rd(4'hC, "rd_hold4", 32'h4);
    exp_code(16'hAB60, 0);
    wr(4'h0, 32'h1234_AB60, 4'b0000);
    check("latency_code", 32'(chk_code), 32'h0000_AB60);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check("busy_hold4", 32'(chk_busy), 32'd1);
    end
    @(posedge clk); #1;
    check("busy_drop4", 32'(chk_busy), 32'd0);

    // HOLD=0 behaves as one cycle
    wr(4'hC, 32'h0, 4'b0011);
    exp_code(16'hAB5F, 0);
    wr(4'h0, 32'h0000_AB5F, 4'hF);
    check("hold0_code", 32'(chk_code), 32'h0000_AB5F);
    check("hold0_busy", 32'(chk_busy), 32'd1);
    @(posedge clk); #1;
    check("hold0_drop", 32'(chk_busy), 32'd0);

    // Four back-to-back codes, HOLD=8
    wr(4'hC, 32'h8, 4'b0011);
    exp_code(16'hAB61, 8); exp_code(16'hAB62, 8); exp_code(16'hAB63, 8); exp_code(16'hAB64, 0);
    for (int i = 0; i < 4; i++) wr(4'h0, 32'h0000_AB61 + 32'(i), 4'hF);
    rd(4'h8, "rd_stat_peak", 32'h0000_0003, ST_MASK);
    repeat (40) @(posedge clk);
    #1;
    rd(4'h8, "rd_stat_drained", 32'h0000_0008, ST_MASK);

    // Overflow with a long-held code on display
    wr(4'hC, 32'd100, 4'b0011);
    exp_code(16'hAB70, 0);
    wr(4'h0, 32'h0000_AB70, 4'hF);
    for (int i = 1; i <= 6; i++) wr(4'h0, 32'h0000_AC00 + 32'(i), 4'hF);
    rd(4'h8, "rd_stat_ovf", 32'h0000_0034, ST_MASK);
    wr(4'h4, 32'h3, 4'b0001);
    check("flush_busy", 32'(chk_busy), 32'd0);
    rd(4'h8, "rd_stat_flush_ovf", 32'h0000_0028, ST_MASK);
    wr(4'h8, 32'h0000_0020, 4'b0001);
    rd(4'h8, "rd_stat_w1c", 32'h0000_0008, ST_MASK);
    rd(4'h4, "rd_ctrl_selfclr", 32'h1);
    rd(4'h0, "rd_code_kept", 32'h0000_AB70);

    // Flush mid-display with two queued
    exp_code(16'hAD00, 0);
    wr(4'h0, 32'h0000_AD00, 4'hF);
    wr(4'h0, 32'h0000_AD01, 4'hF);
    wr(4'h0, 32'h0000_AD02, 4'hF);
    rd(4'h8, "rd_stat_two", 32'h0000_0002, ST_MASK);
    wr(4'h4, 32'h3, 4'b0001);
    check("flush2_busy", 32'(chk_busy), 32'd0);
    check("flush2_code", 32'(chk_code), 32'h0000_AD00);
    rd(4'h8, "rd_stat_flush2", 32'h0000_0008, ST_MASK);

    // Two loads 8 cycles apart: timestamp delta, or zero upper half
    wr(4'hC, 32'h8, 4'b0011);
    exp_code(16'hE000, 8); exp_code(16'hE001, 0);
    wr(4'h0, 32'h0000_E000, 4'hF);
    wr(4'h0, 32'h0000_E001, 4'hF);
    rd(4'h8, "rd_stat_ts1", 32'h0000_0001, ST_MASK);
    ts1 = last_rd[31:16];
    repeat (20) @(posedge clk);
    #1;
`ifdef WB_CHKPT_TSTAMP_EN
    rd(4'h8, "rd_stat_ts_delta", {ts1 + 16'd8, 16'h0008});
`else
    rd(4'h8, "rd_stat_ts_off", 32'h0000_0008);
`endif

    // Reset during a transfer: no ack, nothing pushed
    exp_code(16'h0000, 0);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = 4'h0; wb.dat_w = 32'h0000_5555; wb.sel = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", 32'(wb.ack), 32'd0);
    check("rst_mid_code", 32'(chk_code), 32'h0);
    check("rst_mid_oeb", 32'(chk_oeb), 32'h0000_FFFF);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_idle", 32'(chk_busy), 32'd0);
    rd(4'h0, "rd_code_after_rst", 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("code_q_drained", 32'(code_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
